branch_ext: RTL and testbench



---
 rtl/branch_ext.sv | 51 +++++
 tb/tb_branch_ext.sv | 129 ++++++++++++
 2 files changed

// File: rtl/branch_ext.sv
// B/BL offset extender: combinational byte offset, plus one registered stage with branch target.
// Latency: out is 0 cycles, out_q/target/out_valid are 1 cycle; no backpressure, one input per cycle.
module branch_ext #(
   parameter logic [31:0] PC_BIAS = 32'd8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] ofst,
   input  logic [31:0] pc,
   input  logic        in_valid,
   output logic [31:0] out,
   output logic [31:0] out_q,
   output logic [31:0] target,
   output logic        out_valid
);

   logic [31:0] offset_d, offset_q;
   logic [31:0] target_d, target_q;
   logic        valid_d, valid_q;

   assign out = {{6{ofst[23]}}, ofst, 2'b00};

   always_comb begin
      offset_d = offset_q;
      target_d = target_q;
      valid_d  = 1'b0;
      if (in_valid) begin
         offset_d = out;
         // Plain 32-bit add wraps silently, which matches two's-complement offsets.
         target_d = pc + PC_BIAS + out;
         valid_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         offset_q <= 32'h0;
         target_q <= 32'h0;
         valid_q  <= 1'b0;
      end else begin
         offset_q <= offset_d;
         target_q <= target_d;
         valid_q  <= valid_d;
      end
   end

   assign out_q     = offset_q;
   assign target    = target_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_branch_ext.sv
// Directed bench for branch_ext: combinational extension, registered target, reset and streaming.
module tb_branch_ext;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] ofst;
   logic [31:0] pc;
   logic        in_valid;
   logic [31:0] out;
   logic [31:0] out_q;
   logic [31:0] target;
   logic        out_valid;

   int checks = 0;
   int errors = 0;

   logic [23:0] bnd_in  [5];
   logic [31:0] bnd_exp [5];

   branch_ext #(.PC_BIAS(32'd8)) dut (
      .clk       (clk),
      .reset     (reset),
      .ofst      (ofst),
      .pc        (pc),
      .in_valid  (in_valid),
      .out       (out),
      .out_q     (out_q),
      .target    (target),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bnd_in[0] = 24'h000000; bnd_exp[0] = 32'h00000000;
      bnd_in[1] = 24'h000001; bnd_exp[1] = 32'h00000004;
      bnd_in[2] = 24'h7FFFFF; bnd_exp[2] = 32'h01FFFFFC;
      bnd_in[3] = 24'h800000; bnd_exp[3] = 32'hFE000000;
      bnd_in[4] = 24'hFFFFFF; bnd_exp[4] = 32'hFFFFFFFC;

      reset    = 1'b1;
      in_valid = 1'b0;
      pc       = 32'h0;
      ofst     = 24'b110101010101010101010101;
      #4;
      check("comb_negative", out, 32'hFF555554);

      for (int i = 0; i < 5; i++) begin
         ofst = bnd_in[i];
         #1;
         check($sformatf("comb_boundary_%0d", i), out, bnd_exp[i]);
      end

      step();
      check("reset_out_q", out_q, 32'h0);
      check("reset_target", target, 32'h0);
      check("reset_valid", {31'b0, out_valid}, 32'h0);
      reset = 1'b0;

      // Negative offset target
      pc = 32'h00001000; ofst = 24'hFFFFFE; in_valid = 1'b1;
      step();
      check("neg_target", target, 32'h00001000);
      check("neg_out_q", out_q, 32'hFFFFFFF8);
      check("neg_valid", {31'b0, out_valid}, 32'h1);

      // Idle cycle: registers hold even though inputs change
      in_valid = 1'b0; pc = 32'hDEAD0000; ofst = 24'h000123;
      step();
      check("hold_valid", {31'b0, out_valid}, 32'h0);
      check("hold_target", target, 32'h00001000);
      check("hold_out_q", out_q, 32'hFFFFFFF8);

      // Wrap-around past 0xFFFFFFFF
      pc = 32'hFFFFFFF0; ofst = 24'h000004; in_valid = 1'b1;
      step();
      check("wrap_target", target, 32'h00000008);
      check("wrap_out_q", out_q, 32'h00000010);
      check("wrap_valid", {31'b0, out_valid}, 32'h1);

      // Back-to-back stream
      pc = 32'h0;
      ofst = 24'd1;
      step();
      check("stream0_target", target, 32'h0000000C);
      check("stream0_valid", {31'b0, out_valid}, 32'h1);
      ofst = 24'd2;
      step();
      check("stream1_target", target, 32'h00000010);
      check("stream1_valid", {31'b0, out_valid}, 32'h1);
      ofst = 24'd3;
      step();
      check("stream2_target", target, 32'h00000014);
      check("stream2_valid", {31'b0, out_valid}, 32'h1);

      // Reset mid-stream with in_valid high: reset wins, out still follows ofst
      pc = 32'h00000100; ofst = 24'h123456; reset = 1'b1;
      step();
      check("midrst_out_q", out_q, 32'h0);
      check("midrst_target", target, 32'h0);
      check("midrst_valid", {31'b0, out_valid}, 32'h0);
      check("midrst_comb", out, 32'h0048D158);

      reset = 1'b0;
      step();
      check("post_rst_target", target, 32'h0048D260);
      check("post_rst_out_q", out_q, 32'h0048D158);
      check("post_rst_valid", {31'b0, out_valid}, 32'h1);

      in_valid = 1'b0;
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
